// File: rtl/mm_ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, function codes,
// ALU operations, state numbering and the datapath mux select codes.
package mm_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALUC_ADD = 3'b000;
  localparam logic [2:0] ALUC_SUB = 3'b001;
  localparam logic [2:0] ALUC_AND = 3'b010;
  localparam logic [2:0] ALUC_OR  = 3'b011;
  localparam logic [2:0] ALUC_SLT = 3'b100;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_EXT  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

endpackage

// File: rtl/alu_func_decode.sv
// R-type function field decoder: ALU operation plus a legality flag, shared
// by the decode-stage legality check and the execute-stage ALU control.
module alu_func_decode
  import mm_ctrl_pkg::*;
(
  input  logic [5:0] i_func,
  output logic [2:0] o_aluc,
  output logic       o_valid
);

  always_comb begin
    o_aluc  = ALUC_ADD;
    o_valid = 1'b1;
    case (i_func)
      FN_ADD:  o_aluc = ALUC_ADD;
      FN_SUB:  o_aluc = ALUC_SUB;
      FN_AND:  o_aluc = ALUC_AND;
      FN_OR:   o_aluc = ALUC_OR;
      FN_SLT:  o_aluc = ALUC_SLT;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences IF/ID/EXE/MEM/WB per instruction and
// drives datapath mux selects and write strobes, with a memory-wait watchdog.
module multicycle_ctrl
  import mm_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       link,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_sign,
  output logic [2:0] aluc,
  output logic [1:0] pc_src,
  output logic       retire,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_waitCnt;
  logic            w_waiting;
  logic            w_timeout;
  logic            w_legal;
  logic [2:0]      w_funcAluc;
  logic            w_funcValid;

  alu_func_decode u_func_dec (
    .i_func  (func),
    .o_aluc  (w_funcAluc),
    .o_valid (w_funcValid)
  );

  assign w_waiting = ((r_state == S_IF) || (r_state == S_MEM)) && !mem_ready;
  assign w_timeout = (TIMEOUT > 0) && w_waiting && (r_waitCnt == CW'(TIMEOUT));
  assign state     = r_state;

  always_comb begin
    case (op)
      OP_R:    w_legal = w_funcValid;
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IF;
    else        r_state <= w_next;
  end

  // The counter saturates at TIMEOUT, so with TIMEOUT = 0 it simply idles at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_waitCnt <= '0;
    else if ((w_next != r_state) || w_timeout)
      r_waitCnt <= '0;
    else if (w_waiting && (r_waitCnt != CW'(TIMEOUT)))
      r_waitCnt <= r_waitCnt + 1'b1;
  end

  always_comb begin
    w_next    = r_state;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    i_or_d    = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    reg_dst   = 1'b0;
    link      = 1'b0;
    wb_sel    = WB_ALUOUT;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_REGB;
    ext_sign  = 1'b0;
    aluc      = ALUC_ADD;
    pc_src    = PC_ALU;
    retire    = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    case (r_state)
      S_IF: begin
        alu_src_b = SRCB_FOUR;
        // Reset parks the FSM here; gating keeps the fetch strobes quiet meanwhile.
        if (w_timeout) begin
          bus_err = 1'b1;
        end else if (mem_ready) begin
          pc_write = rst_n;
          ir_write = rst_n;
          w_next   = S_ID;
        end
      end
      S_ID: begin
        alu_src_b = SRCB_BR;
        if ((op == OP_J) || (op == OP_JAL)) begin
          pc_src   = PC_JUMP;
          pc_write = 1'b1;
          retire   = 1'b1;
          w_next   = S_IF;
          if (op == OP_JAL) begin
            reg_write = 1'b1;
            link      = 1'b1;
            wb_sel    = WB_PC;
          end
        end else if (!w_legal) begin
          illegal = 1'b1;
          w_next  = S_IF;
        end else begin
          w_next = S_EXE;
        end
      end
      S_EXE: begin
        // regA is the first ALU operand for every execute form.
        alu_src_a = 1'b1;
        case (op)
          OP_R: begin
            aluc   = w_funcAluc;
            w_next = S_WB;
          end
          OP_ADDI: begin
            alu_src_b = SRCB_EXT;
            ext_sign  = 1'b1;
            w_next    = S_WB;
          end
          OP_ANDI, OP_ORI: begin
            alu_src_b = SRCB_EXT;
            aluc      = (op == OP_ANDI) ? ALUC_AND : ALUC_OR;
            w_next    = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b = SRCB_EXT;
            ext_sign  = 1'b1;
            w_next    = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            aluc     = ALUC_SUB;
            pc_src   = PC_ALUOUT;
            pc_write = (op == OP_BEQ) ? zero : ~zero;
            retire   = 1'b1;
            w_next   = S_IF;
          end
          default: w_next = S_IF;
        endcase
      end
      S_MEM: begin
        i_or_d = 1'b1;
        if (w_timeout) begin
          bus_err = 1'b1;
          w_next  = S_IF;
        end else if (op == OP_SW) begin
          mem_write = 1'b1;
          if (mem_ready) begin
            retire = 1'b1;
            w_next = S_IF;
          end
        end else if (mem_ready) begin
          w_next = S_WB;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        reg_dst   = (op == OP_R);
        wb_sel    = (op == OP_LW) ? WB_MDR : WB_ALUOUT;
        retire    = 1'b1;
        w_next    = S_IF;
      end
      default: w_next = S_IF;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: each instruction is expanded into
// its expected per-cycle control-word sequence and compared cycle by cycle.
module tb_multicycle_ctrl;

  localparam int TO = 4;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, irw, iord, memw, regw, regdst, link;
    logic [1:0] wbsel;
    logic       srca;
    logic [1:0] srcb;
    logic       ext;
    logic [2:0] aluc;
    logic [1:0] pcsrc;
    logic       ret, ill, berr;
  } outs_t;

  typedef struct {
    outs_t      exp;
    logic       ready;
    logic       inIF;
    logic [5:0] opv;
    logic [5:0] funcv;
    logic       zv;
  } step_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] op = '0, func = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic pc_write, ir_write, i_or_d, mem_write, reg_write, reg_dst, link;
  logic [1:0] wb_sel, alu_src_b, pc_src;
  logic alu_src_a, ext_sign, retire, illegal, bus_err;
  logic [2:0] aluc, state;

  step_t plan[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_write(mem_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .link(link), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_sign(ext_sign), .aluc(aluc), .pc_src(pc_src),
    .retire(retire), .illegal(illegal), .bus_err(bus_err), .state(state)
  );

  function automatic outs_t blank(input logic [2:0] st);
    outs_t o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic outs_t fetchWord(input logic rdy);
    outs_t o = blank(3'd0);
    o.srcb = 2'b01;
    o.pcw  = rdy;
    o.irw  = rdy;
    return o;
  endfunction

  // {legal, aluc} for an R-type function field
  function automatic logic [3:0] modelFunc(input logic [5:0] f);
    case (f)
      6'h20:   return 4'b1_000;
      6'h22:   return 4'b1_001;
      6'h24:   return 4'b1_010;
      6'h25:   return 4'b1_011;
      6'h2A:   return 4'b1_100;
      default: return 4'b0_000;
    endcase
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o.st = state; o.pcw = pc_write; o.irw = ir_write; o.iord = i_or_d;
    o.memw = mem_write; o.regw = reg_write; o.regdst = reg_dst; o.link = link;
    o.wbsel = wb_sel; o.srca = alu_src_a; o.srcb = alu_src_b; o.ext = ext_sign;
    o.aluc = aluc; o.pcsrc = pc_src; o.ret = retire; o.ill = illegal; o.berr = bus_err;
    return o;
  endfunction

  task automatic push(input outs_t e, input logic r, input logic isIF,
                      input logic [5:0] o, input logic [5:0] f, input logic z);
    step_t s;
    s.exp = e; s.ready = r; s.inIF = isIF; s.opv = o; s.funcv = f; s.zv = z;
    plan.push_back(s);
  endtask

  task automatic plan_if_timeout();
    outs_t e;
    for (int i = 0; i < TO; i++) push(fetchWord(1'b0), 1'b0, 1'b1, 6'h0, 6'h0, 1'b0);
    e = fetchWord(1'b0);
    e.berr = 1'b1;
    push(e, 1'b0, 1'b1, 6'h0, 6'h0, 1'b0);
  endtask

  task automatic plan_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int ifWait, input int memWait, input bit memTimeout);
    outs_t e;
    logic [3:0] fd;
    logic rnd;
    int zeros;
    fd = modelFunc(f);
    for (int i = 0; i < ifWait; i++) push(fetchWord(1'b0), 1'b0, 1'b1, o, f, z);
    push(fetchWord(1'b1), 1'b1, 1'b1, o, f, z);

    e = blank(3'd1);
    e.srcb = 2'b11;
    rnd = 1'($urandom);
    if (o == OP_J || o == OP_JAL) begin
      e.pcsrc = 2'b10; e.pcw = 1'b1; e.ret = 1'b1;
      if (o == OP_JAL) begin e.regw = 1'b1; e.link = 1'b1; e.wbsel = 2'b10; end
      push(e, rnd, 1'b0, o, f, z);
      return;
    end
    if (!((o == OP_R && fd[3]) || o == OP_ADDI || o == OP_ANDI || o == OP_ORI ||
          o == OP_LW || o == OP_SW || o == OP_BEQ || o == OP_BNE)) begin
      e.ill = 1'b1;
      push(e, rnd, 1'b0, o, f, z);
      return;
    end
    push(e, rnd, 1'b0, o, f, z);

    e = blank(3'd2);
    e.srca = 1'b1;
    rnd = 1'($urandom);
    if (o == OP_BEQ || o == OP_BNE) begin
      e.aluc = 3'b001; e.pcsrc = 2'b01; e.ret = 1'b1;
      e.pcw = (o == OP_BEQ) ? z : !z;
      push(e, rnd, 1'b0, o, f, z);
      return;
    end
    if (o == OP_R) e.aluc = fd[2:0];
    else begin
      e.srcb = 2'b10;
      e.ext  = (o == OP_ADDI || o == OP_LW || o == OP_SW);
      e.aluc = (o == OP_ANDI) ? 3'b010 : (o == OP_ORI) ? 3'b011 : 3'b000;
    end
    push(e, rnd, 1'b0, o, f, z);

    if (o == OP_LW || o == OP_SW) begin
      zeros = memTimeout ? TO : memWait;
      e = blank(3'd3);
      e.iord = 1'b1;
      e.memw = (o == OP_SW);
      for (int i = 0; i < zeros; i++) push(e, 1'b0, 1'b0, o, f, z);
      if (memTimeout) begin
        e.memw = 1'b0; e.berr = 1'b1;
        push(e, 1'b0, 1'b0, o, f, z);
        return;
      end
      if (o == OP_SW) begin
        e.ret = 1'b1;
        push(e, 1'b1, 1'b0, o, f, z);
        return;
      end
      push(e, 1'b1, 1'b0, o, f, z);
    end

    e = blank(3'd4);
    e.regw = 1'b1; e.ret = 1'b1;
    e.regdst = (o == OP_R);
    e.wbsel = (o == OP_LW) ? 2'b01 : 2'b00;
    push(e, 1'($urandom), 1'b0, o, f, z);
  endtask

  // Entry and exit point: 1 time unit after a rising edge.
  task automatic run_plan(input string name, input int maxSteps);
    step_t s;
    outs_t got;
    int n = 0;
    while (plan.size() > 0 && n < maxSteps) begin
      s = plan.pop_front();
      mem_ready = s.ready;
      if (s.inIF) begin
        op = 6'($urandom); func = 6'($urandom); zero = 1'($urandom);
      end else begin
        op = s.opv; func = s.funcv; zero = s.zv;
      end
      @(negedge clk);
      got = sample();
      checks++;
      if (got !== s.exp) begin
        failures++;
        $display("[TB] FAIL %s step %0d: got %h expected %h", name, n, got, s.exp);
      end
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    outs_t e;
    e = fetchWord(1'b0);
    rst_n = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op = 6'($urandom); func = 6'($urandom);
      @(negedge clk);
      checks++;
      if (sample() !== e) begin
        failures++;
        $display("[TB] FAIL reset_hold: got %h expected %h", sample(), e);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    plan_instr(OP_R, 6'h20, 1'b0, 0, 0, 1'b0);
    run_plan("add", 1000);
  endtask

  task automatic test_lw_wait();
    plan_instr(OP_LW, 6'h11, 1'b0, 1, 3, 1'b0);
    run_plan("lw_wait", 1000);
  endtask

  task automatic test_branch();
    plan_instr(OP_BEQ, 6'h00, 1'b1, 0, 0, 1'b0);
    plan_instr(OP_BEQ, 6'h00, 1'b0, 0, 0, 1'b0);
    plan_instr(OP_BNE, 6'h00, 1'b1, 0, 0, 1'b0);
    plan_instr(OP_BNE, 6'h00, 1'b0, 0, 0, 1'b0);
    run_plan("branch", 1000);
  endtask

  task automatic test_jump();
    plan_instr(OP_JAL, 6'h15, 1'b0, 0, 0, 1'b0);
    plan_instr(OP_J, 6'h2A, 1'b1, 2, 0, 1'b0);
    run_plan("jump", 1000);
  endtask

  task automatic test_illegal();
    plan_instr(6'h3F, 6'h20, 1'b0, 0, 0, 1'b0);
    plan_instr(OP_R, 6'h07, 1'b0, 0, 0, 1'b0);
    run_plan("illegal", 1000);
  endtask

  task automatic test_timeout();
    plan_instr(OP_SW, 6'h00, 1'b0, 0, 0, 1'b1);
    plan_instr(OP_LW, 6'h00, 1'b0, 0, 0, 1'b1);
    plan_if_timeout();
    plan_instr(OP_SW, 6'h00, 1'b0, TO, TO, 1'b0);
    plan_instr(OP_ORI, 6'h00, 1'b0, TO, 0, 1'b0);
    run_plan("timeout", 1000);
  endtask

  task automatic test_reset_mid();
    outs_t e;
    plan_instr(OP_SW, 6'h00, 1'b0, 0, 3, 1'b0);
    run_plan("reset_mid", 4);
    plan.delete();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    e = fetchWord(1'b0);
    checks++;
    if (sample() !== e) begin
      failures++;
      $display("[TB] FAIL reset_mid_abort: got %h expected %h", sample(), e);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    plan_instr(OP_ADDI, 6'h00, 1'b0, 2, 0, 1'b0);
    run_plan("after_reset", 1000);
  endtask

  task automatic test_random();
    logic [5:0] ops[12] = '{OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI,
                            OP_ANDI, OP_ORI, OP_LW, OP_SW, 6'h3F, 6'h01};
    logic [5:0] fns[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h07};
    for (int i = 0; i < 60; i++) begin
      plan_instr(ops[$urandom_range(0, 11)], fns[$urandom_range(0, 5)], 1'($urandom),
                 $urandom_range(0, TO), $urandom_range(0, TO), ($urandom_range(0, 9) == 0));
    end
    run_plan("random", 100000);
  endtask

  task automatic test_back_to_back();
    plan_instr(OP_R, 6'h22, 1'b0, 0, 0, 1'b0);
    plan_instr(OP_R, 6'h2A, 1'b0, 0, 0, 1'b0);
    plan_instr(OP_LW, 6'h00, 1'b0, 0, 0, 1'b0);
    plan_instr(OP_SW, 6'h00, 1'b0, 0, 0, 1'b0);
    plan_instr(OP_ANDI, 6'h00, 1'b0, 0, 0, 1'b0);
    run_plan("back_to_back", 1000);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_jump();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
